// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick divider with double-buffered divisors.
// Optional CLK_DIV_SYNC_EN adds the i_Sync phase-align input.
module clk_div_multi #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DIV_W     = 24,
  parameter int unsigned RESET_DIV = 12500000
) (
  input  logic                      i_Clk,
  input  logic                      Reset,
  input  logic [CHANNELS-1:0]       i_En,
  input  logic [CHANNELS-1:0]       i_Load,
  input  logic [CHANNELS*DIV_W-1:0] i_Div,
`ifdef CLK_DIV_SYNC_EN
  input  logic                      i_Sync,
`endif
  output logic [CHANNELS-1:0]       o_Clk,
  output logic [CHANNELS-1:0]       o_Tick,
  output logic [CHANNELS-1:0]       o_Pending
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic sync_c;
`ifdef CLK_DIV_SYNC_EN
  assign sync_c = i_Sync;
`else
  assign sync_c = 1'b0;
`endif

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] shd_q, shd_d;
    logic [DIV_W-1:0] div_in;
    logic [DIV_W-1:0] half_c;
    logic             pend_q, pend_d;
    logic             run_q, run_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             bnd_c;

    assign div_in = i_Div[k*DIV_W +: DIV_W];

    // Next count, divisor hand-over at period boundaries, and output decode.
    // run_q marks a channel already inside a period; a fresh start forces cnt_next=0.
    always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      run_d  = run_q;
      clk_d  = 1'b0;
      tick_d = 1'b0;
      bnd_c  = 1'b0;
      half_c = '0;

      if (!i_En[k]) begin
        cnt_d = '0;
        bnd_c = 1'b1;
      end else if (act_q == '0) begin
        cnt_d = '0;
        bnd_c = 1'b1;
      end else if (!run_q || sync_c || (cnt_q == act_q - ONE)) begin
        cnt_d = '0;
        bnd_c = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end

      if (bnd_c) begin
        act_d  = i_Load[k] ? div_in : shd_q;
        shd_d  = act_d;
        pend_d = 1'b0;
        run_d  = i_En[k] && (act_d != '0);
      end else if (i_Load[k]) begin
        shd_d  = div_in;
        pend_d = 1'b1;
      end

      // High length follows the divisor governing the period that cnt_d belongs to.
      if (i_En[k] && (act_d != '0)) begin
        half_c = act_d - (act_d >> 1);
        clk_d  = (cnt_d < half_c);
        tick_d = (cnt_d == '0);
      end
    end

    always_ff @(posedge i_Clk or posedge Reset) begin
      if (Reset) begin
        cnt_q  <= '0;
        act_q  <= RST_DIV;
        shd_q  <= RST_DIV;
        pend_q <= 1'b0;
        run_q  <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        shd_q  <= shd_d;
        pend_q <= pend_d;
        run_q  <= run_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign o_Clk[k]     = clk_q;
    assign o_Tick[k]    = tick_q;
    assign o_Pending[k] = pend_q;
  end

endmodule
